// File: rtl/cfg_bitstream_sequencer.sv
// rtl/cfg_bitstream_sequencer.sv - sync-word hunter and MSB-first byte-to-word packer for fabric config
// Optional per-session checksum output enabled by defining CFG_CHECKSUM_EN.
module cfg_bitstream_sequencer #(
    parameter logic [31:0] SYNC_WORD        = 32'hFAB0_FAB1,
    parameter logic [31:0] DESYNC_WORD      = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES   = 1_000_000,
    parameter int unsigned WORD_COUNT_WIDTH = 16
) (
    input  logic                        clk_system_i,
    input  logic                        reset_n_i,
    input  logic [7:0]                  byte_i,
    input  logic                        byte_valid_i,
    output logic                        byte_ready_o,
    output logic [31:0]                 cfg_data_o,
    output logic                        cfg_valid_o,
    input  logic                        cfg_ready_i,
    output logic                        active_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [WORD_COUNT_WIDTH-1:0] word_count_o
`ifdef CFG_CHECKSUM_EN
    ,
    output logic [31:0]                 checksum_o
`endif
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [WORD_COUNT_WIDTH-1:0] COUNT_ONE = WORD_COUNT_WIDTH'(1);

    typedef enum logic {
        S_HUNT,
        S_SYNCED
    } state_t;

    state_t                        r_state;
    logic [31:0]                   r_shreg;
    logic [1:0]                    r_idx;
    logic [TW-1:0]                 r_timer;
    logic [31:0]                   r_cfg_data;
    logic                          r_cfg_valid;
    logic                          r_active;
    logic                          r_done;
    logic                          r_error;
    logic [WORD_COUNT_WIDTH-1:0]   r_word_count;
`ifdef CFG_CHECKSUM_EN
    logic [31:0]                   r_checksum;
`endif

    logic        w_accept;
    logic        w_fire;
    logic [31:0] w_shift;

    assign w_accept = byte_valid_i & ~r_cfg_valid;
    assign w_fire   = r_cfg_valid & cfg_ready_i;
    assign w_shift  = {r_shreg[23:0], byte_i};

    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= S_HUNT;
            r_shreg      <= '0;
            r_idx        <= '0;
            r_timer      <= '0;
            r_cfg_data   <= '0;
            r_cfg_valid  <= 1'b0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
`ifdef CFG_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;

            // A pending word blocks byte intake, so completion never collides with session entry.
            if (w_fire) begin
                r_cfg_valid <= 1'b0;
                if (!(&r_word_count)) begin
                    r_word_count <= r_word_count + COUNT_ONE;
                end
`ifdef CFG_CHECKSUM_EN
                r_checksum <= r_checksum + r_cfg_data;
`endif
            end

            case (r_state)
                S_HUNT: begin
                    if (w_accept) begin
                        if (w_shift == SYNC_WORD) begin
                            r_state      <= S_SYNCED;
                            r_active     <= 1'b1;
                            r_word_count <= '0;
                            r_shreg      <= '0;
                            r_idx        <= '0;
                            r_timer      <= '0;
`ifdef CFG_CHECKSUM_EN
                            r_checksum   <= '0;
`endif
                        end else begin
                            r_shreg <= w_shift;
                        end
                    end
                end
                S_SYNCED: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        r_idx   <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_shreg <= '0;
                            if (w_shift == DESYNC_WORD) begin
                                r_state  <= S_HUNT;
                                r_active <= 1'b0;
                                r_done   <= 1'b1;
                            end else begin
                                r_cfg_data  <= w_shift;
                                r_cfg_valid <= 1'b1;
                            end
                        end else begin
                            r_shreg <= w_shift;
                        end
                    end else if (!r_cfg_valid) begin
                        // Only upstream silence counts; a downstream stall never aborts.
                        if (r_timer == TIMER_LAST) begin
                            r_state  <= S_HUNT;
                            r_active <= 1'b0;
                            r_error  <= 1'b1;
                            r_shreg  <= '0;
                            r_idx    <= '0;
                            r_timer  <= '0;
                        end else begin
                            r_timer <= r_timer + TIMER_ONE;
                        end
                    end
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    assign byte_ready_o = ~r_cfg_valid;
    assign cfg_data_o   = r_cfg_data;
    assign cfg_valid_o  = r_cfg_valid;
    assign active_o     = r_active;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign word_count_o = r_word_count;
`ifdef CFG_CHECKSUM_EN
    assign checksum_o   = r_checksum;
`endif

endmodule

// File: tb/tb_cfg_bitstream_sequencer.sv
// tb/tb_cfg_bitstream_sequencer.sv - self-checking bench for cfg_bitstream_sequencer
// Checksum scenario is built only when CFG_CHECKSUM_EN is defined.
module tb_cfg_bitstream_sequencer;

    localparam int TO = 64;
    localparam int WCW = 3;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'h0000_1000;
    localparam int CNT_MAX = (1 << WCW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      byte_i = 8'h00;
    logic            byte_valid_i = 1'b0;
    logic            byte_ready_o;
    logic [31:0]     cfg_data_o;
    logic            cfg_valid_o;
    logic            cfg_ready_i = 1'b0;
    logic            active_o;
    logic            done_o;
    logic            error_o;
    logic [WCW-1:0]  word_count_o;
`ifdef CFG_CHECKSUM_EN
    logic [31:0]     checksum_o;
`endif

    cfg_bitstream_sequencer #(
        .SYNC_WORD(SYNC),
        .DESYNC_WORD(DESYNC),
        .TIMEOUT_CYCLES(TO),
        .WORD_COUNT_WIDTH(WCW)
    ) dut (
        .clk_system_i(clk),
        .reset_n_i(rst_n),
        .byte_i(byte_i),
        .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o),
        .cfg_data_o(cfg_data_o),
        .cfg_valid_o(cfg_valid_o),
        .cfg_ready_i(cfg_ready_i),
        .active_o(active_o),
        .done_o(done_o),
        .error_o(error_o),
        .word_count_o(word_count_o)
`ifdef CFG_CHECKSUM_EN
        ,
        .checksum_o(checksum_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  stim_q[$];
    int done_cnt = 0;
    int err_cnt = 0;
    bit rand_ready = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [31:0] prev_data = 32'h0;

    // Monitor: collects handshaken words and pulses, and checks that a stalled word stays put.
    always @(negedge clk) begin
        #1;
        if (rst_n && prev_valid && !prev_ready) begin
            checks++;
            if ({cfg_valid_o, cfg_data_o} !== {1'b1, prev_data}) begin
                failures++;
                $display("FAIL hold_stable actual=%b/%h required=1/%h", cfg_valid_o, cfg_data_o, prev_data);
            end
        end
        if (rst_n && cfg_valid_o && cfg_ready_i) got_q.push_back(cfg_data_o);
        if (done_o) done_cnt++;
        if (error_o) err_cnt++;
        prev_valid = cfg_valid_o & rst_n;
        prev_ready = cfg_ready_i;
        prev_data  = cfg_data_o;
    end

    task automatic tick();
        @(negedge clk);
        if (rand_ready) cfg_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL send_byte_wait actual=stalled required=accepted byte=%h", b);
        end
        tick();
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        cfg_ready_i = 1'b0;
        rand_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        got_q.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({byte_ready_o, cfg_valid_o, active_o, done_o, error_o, word_count_o, cfg_data_o} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {WCW{1'b0}}, 32'h0}) begin
            failures++;
            $display("FAIL reset_values actual=%b%b%b%b%b cnt=%0d data=%h required=10000 cnt=0 data=0",
                     byte_ready_o, cfg_valid_o, active_o, done_o, error_o, word_count_o, cfg_data_o);
        end
        send_word(SYNC);
        send_word(32'hDEAD_BEEF);
        byte_i = 8'h77;
        byte_valid_i = 1'b1;
        checks++;
        if ({cfg_valid_o, byte_ready_o} !== 2'b10) begin
            failures++;
            $display("FAIL reset_pending_setup actual=%b%b required=10", cfg_valid_o, byte_ready_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_ready_o, cfg_valid_o, active_o, done_o, error_o, word_count_o, cfg_data_o} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {WCW{1'b0}}, 32'h0}) begin
            failures++;
            $display("FAIL reset_async actual=%b%b%b%b%b cnt=%0d data=%h required=10000 cnt=0 data=0",
                     byte_ready_o, cfg_valid_o, active_o, done_o, error_o, word_count_o, cfg_data_o);
        end
        byte_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        cfg_ready_i = 1'b1;
        got_q.delete();
        send_word(32'h1122_3344);
        tick();
        tick();
        checks++;
        if (got_q.size() !== 0 || active_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_hunts actual=words:%0d active:%b required=words:0 active:0", got_q.size(), active_o);
        end
    endtask

    task automatic test_basic_word();
        do_reset();
        cfg_ready_i = 1'b1;
        send_byte(8'h00);
        send_word(SYNC);
        checks++;
        if ({active_o, word_count_o} !== {1'b1, {WCW{1'b0}}}) begin
            failures++;
            $display("FAIL basic_active actual=%b cnt=%0d required=1 cnt=0", active_o, word_count_o);
        end
        send_word(32'h1122_3344);
        checks++;
        if ({cfg_valid_o, cfg_data_o} !== {1'b1, 32'h1122_3344}) begin
            failures++;
            $display("FAIL basic_latency actual=%b/%h required=1/11223344", cfg_valid_o, cfg_data_o);
        end
        tick();
        checks++;
        if ({cfg_valid_o, word_count_o} !== {1'b0, WCW'(1)}) begin
            failures++;
            $display("FAIL basic_complete actual=valid:%b cnt:%0d required=valid:0 cnt:1", cfg_valid_o, word_count_o);
        end
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== 32'h1122_3344) begin
            failures++;
            $display("FAIL basic_forwarded actual=n:%0d required=n:1 word:11223344", got_q.size());
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        bad = 0;
        send_word(SYNC);
        send_word(32'h1122_3344);
        byte_i = 8'h55;
        byte_valid_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if ({byte_ready_o, cfg_valid_o, error_o, cfg_data_o} !== {1'b0, 1'b1, 1'b0, 32'h1122_3344}) begin
                failures++;
                bad++;
                if (bad < 4)
                    $display("FAIL stall_cycle%0d actual=rdy:%b val:%b err:%b data:%h required=rdy:0 val:1 err:0 data:11223344",
                             i, byte_ready_o, cfg_valid_o, error_o, cfg_data_o);
            end
            tick();
        end
        cfg_ready_i = 1'b1;
        send_word(32'h5566_7788);
        tick();
        tick();
        checks++;
        if (got_q.size() !== 2 || got_q[0] !== 32'h1122_3344 || got_q[1] !== 32'h5566_7788 ||
            word_count_o !== WCW'(2) || err_cnt !== 0 || active_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_release actual=n:%0d cnt:%0d errs:%0d act:%b required=n:2 cnt:2 errs:0 act:1",
                     got_q.size(), word_count_o, err_cnt, active_o);
        end
    endtask

    task automatic test_desync();
        do_reset();
        cfg_ready_i = 1'b1;
        send_word(SYNC);
        send_word(32'h0102_0304);
        tick();
        send_word(DESYNC);
        checks++;
        if ({done_o, active_o, cfg_valid_o} !== 3'b100) begin
            failures++;
            $display("FAIL desync_pulse actual=done:%b act:%b val:%b required=done:1 act:0 val:0", done_o, active_o, cfg_valid_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || got_q.size() !== 1 || word_count_o !== WCW'(1)) begin
            failures++;
            $display("FAIL desync_after actual=done:%b n:%0d cnt:%0d required=done:0 n:1 cnt:1", done_o, got_q.size(), word_count_o);
        end
        send_word(SYNC);
        checks++;
        if ({active_o, word_count_o} !== {1'b1, {WCW{1'b0}}} || done_cnt !== 1) begin
            failures++;
            $display("FAIL desync_reopen actual=act:%b cnt:%0d dones:%0d required=act:1 cnt:0 dones:1", active_o, word_count_o, done_cnt);
        end
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        cfg_ready_i = 1'b1;
        send_word(SYNC);
        send_byte(8'hAA);
        send_byte(8'hBB);
        k = 0;
        for (int i = 1; i <= 4 * TO; i++) begin
            tick();
            if (error_o) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k !== TO || active_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_cycle actual=%0d act:%b required=%0d act:0", k, active_o, TO);
        end
        tick();
        checks++;
        if (error_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse_width actual=%b required=0", error_o);
        end
        for (int i = 0; i < 2 * TO; i++) tick();
        send_word(32'h0102_0304);
        tick();
        checks++;
        if (err_cnt !== 1 || got_q.size() !== 0) begin
            failures++;
            $display("FAIL timeout_hunt actual=errs:%0d n:%0d required=errs:1 n:0", err_cnt, got_q.size());
        end
        send_word(SYNC);
        send_word(32'hA1A2_A3A4);
        tick();
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== 32'hA1A2_A3A4) begin
            failures++;
            $display("FAIL timeout_resync actual=n:%0d required=n:1 word:a1a2a3a4", got_q.size());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        cfg_ready_i = 1'b1;
        send_word(SYNC);
        for (int i = 0; i < CNT_MAX + 2; i++) send_word(32'h1000_0000 + i);
        tick();
        checks++;
        if (word_count_o !== WCW'(CNT_MAX) || got_q.size() !== CNT_MAX + 2) begin
            failures++;
            $display("FAIL count_saturate actual=cnt:%0d n:%0d required=cnt:%0d n:%0d", word_count_o, got_q.size(), CNT_MAX, CNT_MAX + 2);
        end
    endtask

    // Reference: sliding 4-byte sync window while hunting, groups of four bytes while synced.
    task automatic run_model(output int exp_count, output int exp_dones);
        bit synced;
        logic [31:0] win;
        logic [7:0] part[$];
        logic [31:0] w;
        synced = 1'b0;
        win = 32'h0;
        exp_q.delete();
        exp_count = 0;
        exp_dones = 0;
        foreach (stim_q[i]) begin
            if (!synced) begin
                win = (win << 8) | 32'(stim_q[i]);
                if (win == SYNC) begin
                    synced = 1'b1;
                    part.delete();
                    exp_count = 0;
                end
            end else begin
                part.push_back(stim_q[i]);
                if (part.size() == 4) begin
                    w = 32'(part[0]) * 32'h0100_0000 + 32'(part[1]) * 32'h0001_0000 + 32'(part[2]) * 32'h100 + 32'(part[3]);
                    part.delete();
                    if (w == DESYNC) begin
                        synced = 1'b0;
                        win = 32'h0;
                        exp_dones++;
                    end else begin
                        exp_q.push_back(w);
                        if (exp_count < CNT_MAX) exp_count++;
                    end
                end
            end
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        stim_q.push_back(w[31:24]);
        stim_q.push_back(w[23:16]);
        stim_q.push_back(w[15:8]);
        stim_q.push_back(w[7:0]);
    endtask

    task automatic test_random_stream();
        int exp_count;
        int exp_dones;
        int bad;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            stim_q.delete();
            repeat ($urandom_range(0, 6)) stim_q.push_back(8'($urandom));
            for (int s = 0; s < 2; s++) begin
                push_word(SYNC);
                repeat ($urandom_range(2, 10)) push_word($urandom);
                if (s == 0) begin
                    push_word(DESYNC);
                    repeat ($urandom_range(0, 5)) stim_q.push_back(8'($urandom));
                end
            end
            run_model(exp_count, exp_dones);
            rand_ready = 1'b1;
            foreach (stim_q[i]) begin
                repeat ($urandom_range(0, 3)) tick();
                send_byte(stim_q[i]);
            end
            rand_ready = 1'b0;
            cfg_ready_i = 1'b1;
            repeat (4) tick();
            bad = 0;
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                failures++;
                $display("FAIL rand%0d_word_total actual=%0d required=%0d", round, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    bad++;
                    if (bad < 4) $display("FAIL rand%0d_word%0d actual=%h required=%h", round, i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (word_count_o !== WCW'(exp_count) || done_cnt !== exp_dones || err_cnt !== 0 || active_o !== 1'b1) begin
                failures++;
                $display("FAIL rand%0d_status actual=cnt:%0d dones:%0d errs:%0d act:%b required=cnt:%0d dones:%0d errs:0 act:1",
                         round, word_count_o, done_cnt, err_cnt, active_o, exp_count, exp_dones);
            end
        end
    endtask

`ifdef CFG_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        cfg_ready_i = 1'b1;
        send_word(SYNC);
        send_word(32'h0000_0005);
        send_word(DESYNC);
        tick();
        checks++;
        if (checksum_o !== 32'h5) begin
            failures++;
            $display("FAIL checksum_held actual=%h required=00000005", checksum_o);
        end
        send_word(SYNC);
        checks++;
        if (checksum_o !== 32'h0) begin
            failures++;
            $display("FAIL checksum_clear actual=%h required=00000000", checksum_o);
        end
        send_word(32'hFFFF_FFFF);
        send_word(32'h0000_0002);
        tick();
        checks++;
        if (checksum_o !== 32'h1) begin
            failures++;
            $display("FAIL checksum_wrap actual=%h required=00000001", checksum_o);
        end
    endtask
`endif

    initial begin
        #20ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_word();
        test_backpressure();
        test_desync();
        test_timeout();
        test_saturation();
        test_random_stream();
`ifdef CFG_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
